// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field widths, fflags layout and skid-buffer states
package fpu_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

   function automatic fflags_t map_status(input logic ovf, input logic udf, input logic nan);
      fflags_t f;
      f.nv = nan;
      f.dz = 1'b0;
      f.of = ovf;
      f.uf = udf;
      f.nx = ovf | udf;
      return f;
   endfunction

endpackage

// File: rtl/fpu_skid_buf.sv
// rtl/fpu_skid_buf.sv - generic 2-entry valid/ready skid buffer
// in_ready and out_valid come straight from the state register.
module fpu_skid_buf
   import fpu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_t   state, state_next;
   logic [W-1:0] main_q, skid_q;
   logic         accept, fire;
   logic         load_main, load_skid, sel_skid;

   assign in_ready  = (state != BUF_FULL);
   assign out_valid = (state != BUF_EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready;

   always_comb begin
      state_next = state;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      sel_skid   = 1'b0;
      case (state)
         BUF_EMPTY: begin
            if (accept) begin
               state_next = BUF_ONE;
               load_main  = 1'b1;
            end
         end
         BUF_ONE: begin
            if (accept && !fire) begin
               state_next = BUF_FULL;
               load_skid  = 1'b1;
            end else if (fire && !accept) begin
               state_next = BUF_EMPTY;
            end else if (accept && fire) begin
               load_main = 1'b1;
            end
         end
         BUF_FULL: begin
            if (fire) begin
               state_next = BUF_ONE;
               load_main  = 1'b1;
               sel_skid   = 1'b1;
            end
         end
         default: state_next = BUF_EMPTY;
      endcase
      // flush wins over any accept in the same cycle
      if (flush) begin
         state_next = BUF_EMPTY;
         load_main  = 1'b0;
         load_skid  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= BUF_EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_next;
         if (load_main) main_q <= sel_skid ? skid_q : in_data;
         if (load_skid) skid_q <= in_data;
      end
   end

endmodule

// File: rtl/fpu_mul_wb_stage.sv
// rtl/fpu_mul_wb_stage.sv - FP32 multiplier writeback stage with sticky fflags
// Optional flush-to-zero of subnormal results under FPU_MUL_WB_FTZ_EN.
module fpu_mul_wb_stage
   import fpu_pkg::*;
#(
   parameter int          TAG_W     = 5,
   parameter logic [31:0] NAN_CANON = FP32_QNAN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_res,
   input  logic             in_ovf,
   input  logic             in_udf,
   input  logic             in_zero,
   input  logic             in_nan,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic [4:0]       out_flags,
   input  logic             csr_we,
   input  logic [4:0]       csr_wdata,
   output logic [4:0]       fflags
);

   localparam int PW = TAG_W + 5 + 32;

   fflags_t        cap_flags;
   logic [31:0]    cap_res;
   logic [PW-1:0]  cap_data, buf_data;
   logic [4:0]     fflags_q;
   logic           fire;
   logic           zero_unused;

   // the multiplier's zero status carries no fflags information
   assign zero_unused = in_zero;

   always_comb begin
      cap_flags = map_status(in_ovf, in_udf, in_nan);
      cap_res   = in_res;
`ifdef FPU_MUL_WB_FTZ_EN
      if (!in_nan && (in_res[MAN_W +: EXP_W] == '0) && (in_res[MAN_W-1:0] != '0)) begin
         cap_res      = {in_res[31], 31'b0};
         cap_flags.uf = 1'b1;
         cap_flags.nx = 1'b1;
      end
`endif
      if (in_nan) cap_res = NAN_CANON;
   end

   assign cap_data = {in_tag, cap_flags, cap_res};

   fpu_skid_buf #(.W(PW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (cap_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_data)
   );

   assign out_res   = buf_data[31:0];
   assign out_flags = buf_data[36:32];
   assign out_tag   = buf_data[PW-1:37];
   assign fire      = out_valid & out_ready;
   assign fflags    = fflags_q;

   // a CSR write merges with, never masks, a retiring result's flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fflags_q <= '0;
      end else begin
         fflags_q <= (csr_we ? csr_wdata : fflags_q) | (fire ? out_flags : 5'b0);
      end
   end

endmodule

// File: tb/tb_fpu_mul_wb_stage.sv
// tb/tb_fpu_mul_wb_stage.sv - self-checking bench for fpu_mul_wb_stage
module tb_fpu_mul_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_res;
   logic        in_ovf, in_udf, in_zero, in_nan;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [4:0]  out_tag;
   logic [4:0]  out_flags;
   logic        csr_we;
   logic [4:0]  csr_wdata;
   logic [4:0]  fflags;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  tag;
      logic [4:0]  flags;
   } item_t;

   item_t      q[$];
   logic [4:0] ff_m;

   always #5 clk = ~clk;

   fpu_mul_wb_stage #(.TAG_W(5), .NAN_CANON(32'h7FC00000)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .in_ovf    (in_ovf),
      .in_udf    (in_udf),
      .in_zero   (in_zero),
      .in_nan    (in_nan),
      .in_tag    (in_tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_tag   (out_tag),
      .out_flags (out_flags),
      .csr_we    (csr_we),
      .csr_wdata (csr_wdata),
      .fflags    (fflags)
   );

   function automatic item_t ref_item(input logic [31:0] r, input logic o, input logic u,
                                      input logic n, input logic [4:0] t);
      item_t e;
      int    expo;
      int    man;
      expo    = (r >> 23) & 8'hFF;
      man     = r & 32'h007FFFFF;
      e.tag   = t;
      e.res   = r;
      e.flags = {n, 1'b0, o, u, o | u};
`ifdef FPU_MUL_WB_FTZ_EN
      if (!n && expo == 0 && man != 0) begin
         e.res   = r & 32'h80000000;
         e.flags = e.flags | 5'b00011;
      end
`endif
      if (n) e.res = 32'h7FC00000;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_res = 0; in_ovf = 0; in_udf = 0; in_zero = 0; in_nan = 0;
      in_tag = 0; flush = 0; csr_we = 0; csr_wdata = 0;
   endtask

   task automatic set_in(input logic [31:0] r, input logic o, input logic u,
                         input logic n, input logic [4:0] t);
      in_valid = 1; in_res = r; in_ovf = o; in_udf = u; in_nan = n; in_tag = t;
      in_zero = (r[30:0] == 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      out_ready = 1;
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      out_ready = 1;
      rst = 1;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (fflags !== 5'b0) begin bad++; $display("FAIL reset_fflags got=%b exp=00000", fflags); end
      total++; if ({out_res, out_tag, out_flags} !== 42'b0) begin bad++; $display("FAIL reset_outputs got=%h/%h/%b exp=0", out_res, out_tag, out_flags); end
      rst = 0;
      set_in(32'h40E00000, 0, 0, 0, 5'd3);
      tick();
      idle_inputs();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_latency got=%b exp=1", out_valid); end
      total++; if (out_res !== 32'h40E00000 || out_tag !== 5'd3 || out_flags !== 5'b0)
         begin bad++; $display("FAIL first_data got=%h/%0d/%b exp=40e00000/3/00000", out_res, out_tag, out_flags); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_pop got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 0;
      set_in(32'h3F800000, 0, 0, 0, 5'd1);
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_one_ready got=%b exp=1", in_ready); end
      set_in(32'h40000000, 0, 0, 0, 5'd2);
      tick();
      idle_inputs();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
      total++; if (out_res !== 32'h3F800000 || out_tag !== 5'd1)
         begin bad++; $display("FAIL bp_head got=%h/%0d exp=3f800000/1", out_res, out_tag); end
      tick();
      total++; if (out_res !== 32'h3F800000 || out_valid !== 1'b1)
         begin bad++; $display("FAIL bp_hold got=%h/%b exp=3f800000/1", out_res, out_valid); end
      out_ready = 1;
      tick();
      total++; if (out_res !== 32'h40000000 || out_tag !== 5'd2 || out_valid !== 1'b1 || in_ready !== 1'b1)
         begin bad++; $display("FAIL bp_second got=%h/%0d/%b/%b exp=40000000/2/1/1", out_res, out_tag, out_valid, in_ready); end
      tick();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL bp_drained got=%b/%b exp=0/1", out_valid, in_ready); end
   endtask

   task automatic test_overflow_csr();
      do_reset();
      set_in(32'h7F800000, 1, 0, 0, 5'd4);
      tick();
      idle_inputs();
      total++; if (out_flags !== 5'b00101) begin bad++; $display("FAIL ovf_flags got=%b exp=00101", out_flags); end
      tick();
      total++; if (fflags !== 5'b00101) begin bad++; $display("FAIL ovf_fflags got=%b exp=00101", fflags); end
      set_in(32'h00000000, 0, 1, 0, 5'd5);
      tick();
      idle_inputs();
      csr_we = 1; csr_wdata = 5'b0;
      total++; if (out_flags !== 5'b00011) begin bad++; $display("FAIL udf_flags got=%b exp=00011", out_flags); end
      tick();
      csr_we = 0;
      total++; if (fflags !== 5'b00011) begin bad++; $display("FAIL csr_merge got=%b exp=00011", fflags); end
   endtask

   task automatic test_nan();
      do_reset();
      set_in(32'h7FC12345, 0, 0, 1, 5'd6);
      tick();
      idle_inputs();
      total++; if (out_res !== 32'h7FC00000 || out_flags !== 5'b10000)
         begin bad++; $display("FAIL nan_canon got=%h/%b exp=7fc00000/10000", out_res, out_flags); end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      csr_we = 1; csr_wdata = 5'b01000;
      out_ready = 0;
      set_in(32'h3F800000, 1, 0, 0, 5'd1);
      tick();
      csr_we = 0;
      set_in(32'h40400000, 0, 0, 0, 5'd2);
      tick();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
      set_in(32'h40800000, 0, 0, 0, 5'd3);
      flush = 1;
      tick();
      idle_inputs();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || fflags !== 5'b01000)
         begin bad++; $display("FAIL flush_full got=%b/%b/%b exp=0/1/01000", out_valid, in_ready, fflags); end
      // flush while ONE with a fire and an accept in the same cycle
      set_in(32'h7F800000, 1, 0, 0, 5'd7);
      tick();
      set_in(32'h41000000, 0, 0, 0, 5'd8);
      out_ready = 1;
      flush = 1;
      tick();
      idle_inputs();
      total++; if (out_valid !== 1'b0 || fflags !== 5'b01101)
         begin bad++; $display("FAIL flush_one got=%b/%b exp=0/01101", out_valid, fflags); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got=%b exp=0", out_valid); end
   endtask

   task automatic test_ftz();
      do_reset();
      set_in(32'h80000001, 0, 0, 0, 5'd9);
      tick();
      idle_inputs();
`ifdef FPU_MUL_WB_FTZ_EN
      total++; if (out_res !== 32'h80000000 || out_flags !== 5'b00011)
         begin bad++; $display("FAIL ftz got=%h/%b exp=80000000/00011", out_res, out_flags); end
`else
      total++; if (out_res !== 32'h80000001 || out_flags !== 5'b00000)
         begin bad++; $display("FAIL ftz_off got=%h/%b exp=80000001/00000", out_res, out_flags); end
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      csr_we = 1; csr_wdata = 5'b10101;
      out_ready = 0;
      set_in(32'h3F800000, 0, 0, 0, 5'd1);
      tick();
      csr_we = 0;
      set_in(32'h40000000, 0, 0, 0, 5'd2);
      tick();
      idle_inputs();
      #2 rst = 1;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || fflags !== 5'b0)
         begin bad++; $display("FAIL async_reset got=%b/%b/%b exp=0/1/00000", out_valid, in_ready, fflags); end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_random();
      logic       acc, fir;
      logic [31:0] r;
      do_reset();
      q.delete();
      ff_m = 5'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         total++; if (in_ready !== (q.size() < 2))
            begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2); end
         total++; if (out_valid !== (q.size() > 0))
            begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() > 0); end
         if (q.size() > 0) begin
            total++; if ({out_res, out_tag, out_flags} !== q[0])
               begin bad++; $display("FAIL rnd_data cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc,
                     out_res, out_tag, out_flags, q[0].res, q[0].tag, q[0].flags); end
         end
         total++; if (fflags !== ff_m)
            begin bad++; $display("FAIL rnd_fflags cyc=%0d got=%b exp=%b", cyc, fflags, ff_m); end

         r = $urandom;
         if ($urandom_range(0, 3) == 0) r = r & 32'h807FFFFF;
         set_in(r, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 7) == 0, 5'($urandom));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         csr_we    = ($urandom_range(0, 15) == 0);
         csr_wdata = 5'($urandom);

         acc  = in_valid && (q.size() < 2);
         fir  = out_ready && (q.size() > 0);
         ff_m = (csr_we ? csr_wdata : ff_m) | (fir ? q[0].flags : 5'b0);
         if (fir) void'(q.pop_front());
         if (acc && !flush) q.push_back(ref_item(in_res, in_ovf, in_udf, in_nan, in_tag));
         if (flush) q.delete();
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      out_ready = 1;
      idle_inputs();
      test_reset();
      test_backpressure();
      test_overflow_csr();
      test_nan();
      test_flush();
      test_ftz();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_mul_wb_stage.md
Name: fpu_mul_wb_stage

Overview:
Registered writeback stage directly downstream of the combinational FP32 multiplier.
- Captures the product and its status flags (overflow, underflow, zero, NaN) behind a valid/ready handshake.
- Buffers results in a 2-entry skid buffer and maps status to RISC-V fflags (NV DZ OF UF NX).
- Keeps the sticky fflags CSR value, which the CSR unit can read and overwrite.

Parameters:
TAG_W, 5, width of destination-register tag carried with each result
NAN_CANON, 32'h7FC00000, canonical quiet NaN forced onto the output whenever nan_i is set

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  multiplier result valid
in_ready  output  1  stage can accept; registered, equals !full
in_res  input  32  multiplier S output
in_ovf  input  1  multiplier overflow
in_udf  input  1  multiplier underflow
in_zero  input  1  multiplier zero
in_nan  input  1  multiplier NaN
in_tag  input  TAG_W  destination tag
flush  input  1  synchronous discard of all buffered entries
out_valid  output  1  result available
out_ready  input  1  consumer accepts
out_res  output  32  result word
out_tag  output  TAG_W  tag
out_flags  output  5  per-result flags {NV,DZ,OF,UF,NX}
csr_we  input  1  fflags write strobe
csr_wdata  input  5  fflags write value
fflags  output  5  sticky accumulated flags

Behaviour:
- Reset (async, rst=1):
  - Both buffer entries are invalid.
  - in_ready=1, out_valid=0.
  - out_res, out_tag, out_flags and fflags are 0.
- Flag mapping at capture:
  - NV = in_nan.
  - DZ = 0.
  - OF = in_ovf.
  - UF = in_udf.
  - NX = in_ovf | in_udf.
  - If in_nan=1, the stored result is NAN_CANON regardless of in_res.
- Handshakes:
  - Accept occurs on in_valid & in_ready.
  - Fire occurs on out_valid & out_ready.
  - in_valid may be held high while in_ready=0; the same data must be presented until accepted.
  - Once asserted, out_valid and out_* stay stable until fire.
- Buffer state machine:
  - EMPTY: accept -> ONE.
  - ONE: accept & !fire -> FULL. fire & !accept -> EMPTY. Accept & fire together stay in ONE, with the new data in the main register.
  - FULL: fire -> ONE (skid entry moves to main). in_ready=0.
- Latency and throughput:
  - Latency: 1 cycle from accept to out_valid when EMPTY.
  - Throughput: 1 per cycle when out_ready is held high.
  - in_ready depends on registered state only; there is no combinational path from out_ready to in_ready.
- flush:
  - The next state is EMPTY. Anything accepted in the flush cycle is discarded.
  - A fire in the flush cycle still counts toward fflags.
  - flush has priority over accept.
- fflags:
  - fflags_next = (csr_we ? csr_wdata : fflags) | (fire ? out_flags : 5'b0).
  - A CSR write and a retiring flag in the same cycle therefore merge; the write never masks a retiring flag.
- Reset asserted mid-transfer drops all entries immediately and clears fflags.

Optional Feature:
Macro FPU_MUL_WB_FTZ_EN.
- Defined: at capture, a result with exponent 0 and nonzero mantissa is replaced by a signed zero (sign bit kept), and UF and NX are set.
- Undefined: subnormal results pass through unchanged, and flags come only from the mapping above.

Decomposition:
- Package fpu_pkg holds:
  - typedef fflags_t (packed struct nv, dz, of, uf, nx)
  - flag bit index localparams
  - FP32_QNAN = 32'h7FC00000
  - FP32 field widths (EXP_W=8, MAN_W=23)
- Sub-module fpu_skid_buf: a generic 2-entry valid/ready skid buffer, parameterised on payload width. The flag mapping and the fflags register stay in the top module.

Test Plan:
- Reset: rst=1 with out_ready=1 -> out_valid=0, in_ready=1, fflags=0. Then accept in_res=0x40E00000, tag=3 -> next cycle out_res=0x40E00000, out_tag=3, out_flags=0.
- Backpressure: out_ready=0, push 0x3F800000 then 0x40000000 -> in_ready=0 after the second accept. Raise out_ready -> both pop in order, and in_ready returns to 1.
- Overflow then CSR merge: in_res=0x7F800000, in_ovf=1, fires -> out_flags=5'b00101, fflags=5'b00101. A later fire with in_udf=1 in the same cycle as csr_we=1, csr_wdata=0 -> fflags=5'b00011.
- NaN canonicalisation: in_nan=1, in_res=0x7FC12345 -> out_res=0x7FC00000, out_flags=5'b10000.
- Flush: stage holds 2 entries, flush=1 with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, fflags unchanged.
- FTZ (macro defined): in_res=0x80000001 -> out_res=0x80000000, out_flags=5'b00011. With the macro undefined -> out_res=0x80000001, out_flags=0.
